// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand interface (feeder and array).
package systolic_pkg;

  localparam int N_DEF  = 3;
  localparam int DW_DEF = 4;

  // Largest matrix the element selector supports; narrower buses are zero-extended.
  localparam int MAX_N    = 8;
  localparam int MAX_DW   = 16;
  localparam int MAX_BITS = MAX_N * MAX_N * MAX_DW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // Element (i,j) of a row-major flat matrix bus of n x n elements, dw bits each.
  function automatic logic [MAX_DW-1:0] elem_sel(input logic [MAX_BITS-1:0] mat,
                                                 input int n, input int dw,
                                                 input int i, input int j);
    logic [MAX_BITS-1:0] sh;
    logic [MAX_DW-1:0]   mask;
    sh   = mat >> ((i * n + j) * dw);
    mask = (MAX_DW'(1) << dw) - MAX_DW'(1);
    return MAX_DW'(sh) & mask;
  endfunction

endpackage

// File: rtl/systolic_job_buf.sv
// One-entry job holding register; a simultaneous read and write drains and refills it.
module systolic_job_buf #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  logic         i_rd_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic         r_full;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst)          r_full <= 1'b0;
    else if (i_wr_en) r_full <= 1'b1;
    else if (i_rd_en) r_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_data <= i_data;
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/systolic_feeder.sv
// Streams whole NxN A/B jobs into a systolic array as N skew-free beats plus a zero flush.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DW    = DW_DEF,
  parameter int FLUSH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N*DW-1:0]   matrix_a_in,
  output logic [N*DW-1:0]   matrix_b_in,
  output logic              valid_in,
  output logic              busy,
  output logic              done
);

  localparam int MW = N * N * DW;
  localparam int CW = $clog2(((N > FLUSH) ? N : FLUSH) + 1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [MW-1:0]   r_cur_a, r_cur_b;
  logic [N*DW-1:0] r_out_a, r_out_b;
  logic            r_valid, r_done;

  logic            w_accept, w_pend_full, w_pend_wr, w_pend_rd;
  logic            w_last_flush, w_chain, w_start;
  logic [MW-1:0]   w_pend_a, w_pend_b, w_new_a, w_new_b, w_src_a, w_src_b;
  logic [CW-1:0]   w_k;
  logic [N*DW-1:0] w_beat_a, w_beat_b;

  assign in_ready     = !rst && (r_state == ST_IDLE || !w_pend_full);
  assign w_accept     = in_valid && in_ready;
  assign w_last_flush = (r_state == ST_FLUSH) && (r_cnt == CW'(FLUSH - 1));

  // An offer taken on the final flush edge with nothing pending bypasses the buffer,
  // otherwise it would be parked behind an FSM that is about to go idle.
  assign w_chain   = w_last_flush && (w_pend_full || w_accept);
  assign w_start   = ((r_state == ST_IDLE) && w_accept) || w_chain;
  assign w_pend_rd = w_last_flush && w_pend_full;
  assign w_pend_wr = w_accept && ((r_state == ST_STREAM) ||
                                  (r_state == ST_FLUSH && !w_last_flush));

  systolic_job_buf #(.W(2 * MW)) u_job_buf (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (w_pend_wr),
    .i_rd_en (w_pend_rd),
    .i_data  ({mat_a, mat_b}),
    .o_data  ({w_pend_a, w_pend_b}),
    .o_full  (w_pend_full)
  );

  assign w_new_a = w_pend_rd ? w_pend_a : mat_a;
  assign w_new_b = w_pend_rd ? w_pend_b : mat_b;
  assign w_src_a = w_start ? w_new_a : r_cur_a;
  assign w_src_b = w_start ? w_new_b : r_cur_b;
  assign w_k     = w_start ? '0 : r_cnt;

  // Beat k: A lane i carries A[i][k] (column k), B lane j carries B[k][j] (row k).
  always_comb begin
    w_beat_a = '0;
    w_beat_b = '0;
    for (int l = 0; l < N; l++) begin
      w_beat_a[l*DW +: DW] = DW'(elem_sel(MAX_BITS'(w_src_a), N, DW, l, int'(w_k)));
      w_beat_b[l*DW +: DW] = DW'(elem_sel(MAX_BITS'(w_src_b), N, DW, int'(w_k), l));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_STREAM;
      ST_STREAM: if (r_cnt == CW'(N)) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (w_last_flush) w_state_nxt = w_chain ? ST_STREAM : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_cnt: beats already sent while streaming, elapsed flush cycles while flushing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_out_a <= '0;
      r_out_b <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_out_a <= '0;
      r_out_b <= '0;
      r_valid <= 1'b0;
      r_done  <= w_last_flush;
      if (w_start) begin
        r_cnt   <= CW'(1);
        r_out_a <= w_beat_a;
        r_out_b <= w_beat_b;
        r_valid <= 1'b1;
      end else if (r_state == ST_STREAM && r_cnt < CW'(N)) begin
        r_cnt   <= r_cnt + CW'(1);
        r_out_a <= w_beat_a;
        r_out_b <= w_beat_b;
        r_valid <= 1'b1;
      end else if (r_state == ST_STREAM || w_last_flush) begin
        r_cnt <= '0;
      end else if (r_state == ST_FLUSH) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_cur_a <= w_new_a;
      r_cur_b <= w_new_b;
    end
  end

  assign matrix_a_in = r_out_a;
  assign matrix_b_in = r_out_b;
  assign valid_in    = r_valid;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=3, DW=4, FLUSH=6): vector table plus corner sequences.
module tb_systolic_feeder;

  localparam logic [35:0] MA = 36'h987654321;
  localparam logic [35:0] MI = 36'h100010001;
  localparam logic [35:0] MX = 36'hFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] mat_a = '0, mat_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, valid_in, busy, done;
  logic [11:0] matrix_a_in, matrix_b_in;

  int n_chk = 0;
  int n_fail = 0;

  systolic_feeder #(.N(3), .DW(4), .FLUSH(6)) dut (
    .clk(clk), .rst(rst), .mat_a(mat_a), .mat_b(mat_b), .in_valid(in_valid),
    .in_ready(in_ready), .matrix_a_in(matrix_a_in), .matrix_b_in(matrix_b_in),
    .valid_in(valid_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld;
    logic [35:0] a, b;
    logic        rdy;
    logic        vo;
    logic [11:0] ao, bo;
    logic        dn, bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [35:0] a, input logic [35:0] b,
                     input logic rdy, input logic vo, input logic [11:0] ao,
                     input logic [11:0] bo, input logic dn, input logic bsy);
    vec_t t;
    t.rst = r; t.vld = v; t.a = a; t.b = b; t.rdy = rdy;
    t.vo = vo; t.ao = ao; t.bo = bo; t.dn = dn; t.bsy = bsy;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vq[$];
    int dq[$];
    int acc, t0, nv, nd;
    int exp_v[9] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
    int exp_d[3] = '{9, 18, 27};

    // Reset and a single job
    add(1, 0, '0, '0, 0, 0, 12'h0, 12'h0, 0, 0);
    add(1, 0, '0, '0, 0, 0, 12'h0, 12'h0, 0, 0);
    add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 0, 0);
    add(0, 1, MA, MA, 1, 1, 12'h741, 12'h321, 0, 1);
    add(0, 0, '0, '0, 1, 1, 12'h852, 12'h654, 0, 1);
    add(0, 0, '0, '0, 1, 1, 12'h963, 12'h987, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 0, 1);
    add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 1, 0);
    add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 0, 0);
    // Pending job taken in STREAM; changed offers while full are ignored
    add(0, 1, MA, MA, 1, 1, 12'h741, 12'h321, 0, 1);
    add(0, 1, MA, MI, 1, 1, 12'h852, 12'h654, 0, 1);
    add(0, 1, MX, MX, 0, 1, 12'h963, 12'h987, 0, 1);
    for (int i = 0; i < 6; i++)
      add(0, (i % 2 == 1), MX, MX, 0, 0, 12'h0, 12'h0, 0, 1);
    add(0, 1, MX, MX, 0, 1, 12'h741, 12'h001, 1, 1);
    add(0, 0, '0, '0, 1, 1, 12'h852, 12'h010, 0, 1);
    add(0, 0, '0, '0, 1, 1, 12'h963, 12'h100, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 0, 1);
    add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 1, 0);
    add(0, 0, '0, '0, 1, 0, 12'h0, 12'h0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].vld; mat_a = tbl[i].a; mat_b = tbl[i].b;
      #1;
      chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      tick();
      chk($sformatf("row%0d valid_in", i), 64'(valid_in), 64'(tbl[i].vo));
      chk($sformatf("row%0d matrix_a_in", i), 64'(matrix_a_in), 64'(tbl[i].ao));
      chk($sformatf("row%0d matrix_b_in", i), 64'(matrix_b_in), 64'(tbl[i].bo));
      chk($sformatf("row%0d done", i), 64'(done), 64'(tbl[i].dn));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
    end
    in_valid = 1'b0;

    // in_valid held for three jobs: back-to-back streaming, done every 9 cycles
    acc = 0; t0 = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      in_valid = (acc < 3); mat_a = MA; mat_b = MA;
      #1;
      if (in_valid && in_ready) begin
        if (acc == 0) t0 = cyc;
        acc++;
      end
      tick();
      if (valid_in) vq.push_back(cyc - t0);
      if (done) dq.push_back(cyc - t0);
    end
    in_valid = 1'b0;
    chk("b2b accepts", 64'(acc), 64'd3);
    chk("b2b beat count", 64'(vq.size()), 64'd9);
    chk("b2b done count", 64'(dq.size()), 64'd3);
    for (int i = 0; i < 9; i++)
      chk($sformatf("b2b beat%0d cycle", i), 64'((i < vq.size()) ? vq[i] : -1), 64'(exp_v[i]));
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b done%0d cycle", i), 64'((i < dq.size()) ? dq[i] : -1), 64'(exp_d[i]));

    // Reset at the second beat with a pending job loaded
    in_valid = 1'b1; mat_a = MA; mat_b = MA;
    tick();
    mat_b = MI;
    tick();
    chk("rst-abort beat1", 64'(matrix_a_in), 64'h852);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("rst valid_in", 64'(valid_in), 64'd0);
    chk("rst matrix_a_in", 64'(matrix_a_in), 64'd0);
    chk("rst matrix_b_in", 64'(matrix_b_in), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    rst = 1'b0;
    nv = 0; nd = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (valid_in) nv++;
      if (done) nd++;
    end
    chk("post-rst beats", 64'(nv), 64'd0);
    chk("post-rst done", 64'(nd), 64'd0);
    chk("post-rst in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
